pc_nway: RTL and testbench

- Parametrised N-lane fetch program-counter generator; successor to the two-lane PC unit.
- Sits at the head of the fetch stage and produces LANES consecutive instruction addresses per cycle.
- Accepts per-lane redirects from execute and resolves them in program order.
- Adds over the two-lane unit: a pending-redirect register that holds a redirect across fetch stalls, optional fetch-group alignment with per-lane valid mask, a registered flush pulse, a misalignment flag and a redirect counter.

---
 rtl/pc_nway.sv | 144 ++++++++++++++
 tb/tb_pc_nway.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_nway.sv
// N-lane fetch PC generator: in-order redirect resolution, a pending redirect held across
// stalls, optional fetch-group alignment with per-lane valid, flush/misalign pulses and a redirect counter.
module pc_nway #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      LANES       = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      ALIGN_GROUP = 1,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [2*LANES-1:0]     redir_src,
  input  logic [WIDTH*LANES-1:0] redir_target,
  input  logic [WIDTH*LANES-1:0] redir_alu,
  output logic [WIDTH*LANES-1:0] pc_lane,
  output logic [WIDTH*LANES-1:0] pc_plus4,
  output logic [WIDTH-1:0]       pc_base,
  output logic [LANES-1:0]       lane_valid,
  output logic                   flush,
  output logic                   misalign_err,
  output logic [CNT_W-1:0]       redirect_count
);

  localparam logic [WIDTH-1:0] GROUP_BYTES = WIDTH'(4 * LANES);
  localparam logic [WIDTH-1:0] GROUP_MASK  = ~(GROUP_BYTES - WIDTH'(1));
  localparam logic [WIDTH-1:0] LANE_MASK   = WIDTH'(LANES - 1);
  localparam logic [WIDTH-1:0] WORD_MASK   = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RESET_BASE  = (ALIGN_GROUP != 0) ? (RESET_PC & GROUP_MASK) : RESET_PC;

  logic [WIDTH-1:0] base_q, base_d;
  logic [LANES-1:0] valid_q, valid_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] pend_a_q, pend_a_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_v;
  logic [WIDTH-1:0] win_a;
  logic             win_mis;
  logic             tgt_v;
  logic [WIDTH-1:0] tgt_a;
  logic [WIDTH-1:0] tgt_off;
  logic [LANES-1:0] redir_mask;

  // Walk lanes from highest to lowest so the oldest (lowest-index) redirect has the final say.
  always_comb begin
    win_v   = 1'b0;
    win_a   = '0;
    win_mis = 1'b0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      case (redir_src[2*i +: 2])
        2'b01: begin
          win_v   = 1'b1;
          win_a   = redir_target[WIDTH*i +: WIDTH] & WORD_MASK;
          win_mis = |redir_target[WIDTH*i +: 2];
        end
        2'b10: begin
          win_v   = 1'b1;
          win_a   = redir_alu[WIDTH*i +: WIDTH] & WORD_MASK;
          win_mis = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tgt_v   = win_v | pend_v_q;
  assign tgt_a   = win_v ? win_a : pend_a_q;
  assign tgt_off = (tgt_a >> 2) & LANE_MASK;

  always_comb begin
    redir_mask = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      redir_mask[i] = (WIDTH'(i) >= tgt_off);
    end
  end

  always_comb begin
    base_d   = base_q;
    valid_d  = valid_q;
    pend_v_d = pend_v_q;
    pend_a_d = pend_a_q;
    if (en) begin
      pend_v_d = 1'b0;
      if (tgt_v) begin
        if (ALIGN_GROUP != 0) begin
          base_d  = tgt_a & GROUP_MASK;
          valid_d = redir_mask;
        end else begin
          base_d  = tgt_a;
          valid_d = '1;
        end
      end else begin
        base_d  = base_q + GROUP_BYTES;
        valid_d = '1;
      end
    end else if (win_v) begin
      // A newer redirect during a stall replaces whatever was pending.
      pend_v_d = 1'b1;
      pend_a_d = win_a;
    end
    flush_d = win_v;
    mis_d   = win_mis;
    cnt_d   = (win_v && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= RESET_BASE;
      valid_q  <= '1;
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      flush_q  <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      base_q   <= base_d;
      valid_q  <= valid_d;
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      flush_q  <= flush_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    pc_lane  = '0;
    pc_plus4 = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      pc_lane[WIDTH*i +: WIDTH]  = base_q + WIDTH'(4 * i);
      pc_plus4[WIDTH*i +: WIDTH] = base_q + WIDTH'(4 * i + 4);
    end
  end

  assign pc_base        = base_q;
  assign lane_valid     = valid_q;
  assign flush          = flush_q;
  assign misalign_err   = mis_q;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_nway.sv
// Bench for pc_nway: directed vector table for the key scenarios plus randomized stimulus
// checked against an address-arithmetic model, on an aligned and an unaligned/small-counter instance.
module tb_pc_nway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  r_src;
  logic [63:0] r_tgt;
  logic [63:0] r_alu;

  logic [63:0] a_lane, a_p4, b_lane, b_p4;
  logic [31:0] a_base, b_base;
  logic [1:0]  a_valid, b_valid;
  logic        a_fl, a_mis, b_fl, b_mis;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_nway #(.WIDTH(32), .LANES(2), .RESET_PC(32'h0), .ALIGN_GROUP(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .redir_src(r_src), .redir_target(r_tgt), .redir_alu(r_alu),
    .pc_lane(a_lane), .pc_plus4(a_p4), .pc_base(a_base), .lane_valid(a_valid),
    .flush(a_fl), .misalign_err(a_mis), .redirect_count(a_cnt));

  pc_nway #(.WIDTH(32), .LANES(2), .RESET_PC(32'h104), .ALIGN_GROUP(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .redir_src(r_src), .redir_target(r_tgt), .redir_alu(r_alu),
    .pc_lane(b_lane), .pc_plus4(b_p4), .pc_base(b_base), .lane_valid(b_valid),
    .flush(b_fl), .misalign_err(b_mis), .redirect_count(b_cnt));

  // Reference model state, index 0 = dut_a, 1 = dut_b
  logic [31:0] m_base[2];
  logic [1:0]  m_valid[2];
  bit          m_pv[2];
  logic [31:0] m_pa[2];
  bit          m_fl[2];
  bit          m_mis[2];
  int          m_cnt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_apply(input int c, input logic [31:0] a);
    if (c == 0) begin
      m_base[c]  = a - (a % 8);
      m_valid[c] = ((a % 8) / 4 == 0) ? 2'b11 : 2'b10;
    end else begin
      m_base[c]  = a;
      m_valid[c] = 2'b11;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      int          w;
      logic [31:0] wa;
      bit          wm;
      int          cmax;
      cmax = (c == 0) ? 65535 : 7;
      if (!rst_n) begin
        m_base[c]  = (c == 0) ? 32'h0 : 32'h104;
        m_valid[c] = 2'b11;
        m_pv[c]    = 0;
        m_fl[c]    = 0;
        m_mis[c]   = 0;
        m_cnt[c]   = 0;
        continue;
      end
      w  = -1;
      wa = '0;
      wm = 0;
      for (int i = 0; i < 2; i++) begin
        if (w < 0) begin
          if (r_src[2*i +: 2] == 2'd1) begin
            w  = i;
            wa = r_tgt[32*i +: 32] & 32'hFFFF_FFFC;
            wm = (r_tgt[32*i +: 2] != 2'd0);
          end else if (r_src[2*i +: 2] == 2'd2) begin
            w  = i;
            wa = r_alu[32*i +: 32] & 32'hFFFF_FFFC;
          end
        end
      end
      m_fl[c]  = (w >= 0);
      m_mis[c] = wm;
      if (w >= 0 && m_cnt[c] < cmax) m_cnt[c]++;
      if (en) begin
        if (w >= 0) model_apply(c, wa);
        else if (m_pv[c]) model_apply(c, m_pa[c]);
        else begin
          m_base[c]  = m_base[c] + 32'd8;
          m_valid[c] = 2'b11;
        end
        m_pv[c] = 0;
      end else if (w >= 0) begin
        m_pv[c] = 1;
        m_pa[c] = wa;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int c);
    logic [31:0] ab, ac;
    logic [63:0] al, ap;
    logic [1:0]  av;
    logic        af, am;
    if (c == 0) begin
      ab = a_base; al = a_lane; ap = a_p4; av = a_valid; af = a_fl; am = a_mis; ac = 32'(a_cnt);
    end else begin
      ab = b_base; al = b_lane; ap = b_p4; av = b_valid; af = b_fl; am = b_mis; ac = 32'(b_cnt);
    end
    chk($sformatf("c%0d pc_base", c), ab, m_base[c]);
    chk($sformatf("c%0d lane_valid", c), 32'(av), 32'(m_valid[c]));
    chk($sformatf("c%0d flush", c), 32'(af), 32'(m_fl[c]));
    chk($sformatf("c%0d misalign", c), 32'(am), 32'(m_mis[c]));
    chk($sformatf("c%0d count", c), ac, 32'(m_cnt[c]));
    chk($sformatf("c%0d pc_lane0", c), al[31:0], m_base[c]);
    chk($sformatf("c%0d pc_lane1", c), al[63:32], m_base[c] + 32'd4);
    chk($sformatf("c%0d pc_plus4_0", c), ap[31:0], m_base[c] + 32'd4);
    chk($sformatf("c%0d pc_plus4_1", c), ap[63:32], m_base[c] + 32'd8);
  endtask

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  src;
    logic [31:0] t0, t1, a0, a1;
    logic [31:0] e_base;
    logic [1:0]  e_valid;
    logic        e_fl, e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [3:0] s, logic [31:0] t0, logic [31:0] t1,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] eb, logic [1:0] ev,
                              logic ef, logic em, logic [15:0] ec);
    vec_t v;
    v.rst_n = r; v.en = e; v.src = s; v.t0 = t0; v.t1 = t1; v.a0 = a0; v.a1 = a1;
    v.e_base = eb; v.e_valid = ev; v.e_fl = ef; v.e_mis = em; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    rst_n = 1'b0; en = 1'b1; r_src = '0; r_tgt = '0; r_alu = '0;
    for (int c = 0; c < 2; c++) begin
      m_base[c] = '0; m_valid[c] = '0; m_pv[c] = 0; m_pa[c] = '0;
      m_fl[c] = 0; m_mis[c] = 0; m_cnt[c] = 0;
    end

    //             rst en  src    t0          t1          a0            a1          base          valid fl mis cnt
    tbl[0]  = mk(0, 1, 4'h0, 0,          0,          0,            0,          32'h0,        2'b11, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4'h0, 0,          0,          0,            0,          32'h0,        2'b11, 0, 0, 0);
    tbl[2]  = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h8,        2'b11, 0, 0, 0);
    tbl[3]  = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h10,       2'b11, 0, 0, 0);
    tbl[4]  = mk(1, 1, 4'h9, 32'h100,    0,          0,            32'h203,    32'h100,      2'b11, 1, 0, 1);
    tbl[5]  = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h108,      2'b11, 0, 0, 1);
    tbl[6]  = mk(1, 1, 4'h8, 0,          0,          0,            32'h207,    32'h200,      2'b10, 1, 0, 2);
    tbl[7]  = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h208,      2'b11, 0, 0, 2);
    tbl[8]  = mk(1, 0, 4'h1, 32'h400,    0,          0,            0,          32'h208,      2'b11, 1, 0, 3);
    tbl[9]  = mk(1, 0, 4'h1, 32'h500,    0,          0,            0,          32'h208,      2'b11, 1, 0, 4);
    tbl[10] = mk(1, 0, 4'h0, 0,          0,          0,            0,          32'h208,      2'b11, 0, 0, 4);
    tbl[11] = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h500,      2'b11, 0, 0, 4);
    tbl[12] = mk(1, 1, 4'h1, 32'h302,    0,          0,            0,          32'h300,      2'b11, 1, 1, 5);
    tbl[13] = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h308,      2'b11, 0, 0, 5);
    tbl[14] = mk(0, 1, 4'h1, 32'h800,    0,          0,            0,          32'h0,        2'b11, 0, 0, 0);
    tbl[15] = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h8,        2'b11, 0, 0, 0);
    tbl[16] = mk(1, 0, 4'h1, 32'h900,    0,          0,            0,          32'h8,        2'b11, 1, 0, 1);
    tbl[17] = mk(0, 0, 4'h0, 0,          0,          0,            0,          32'h0,        2'b11, 0, 0, 0);
    tbl[18] = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h8,        2'b11, 0, 0, 0);
    tbl[19] = mk(1, 1, 4'h7, 0,          32'h604,    0,            0,          32'h600,      2'b10, 1, 0, 1);
    tbl[20] = mk(1, 1, 4'h2, 0,          0,          32'hFFFFFFF8, 0,          32'hFFFFFFF8, 2'b11, 1, 0, 2);
    tbl[21] = mk(1, 1, 4'h0, 0,          0,          0,            0,          32'h0,        2'b11, 0, 0, 2);

    @(negedge clk);
    for (int k = 0; k < 22; k++) begin
      rst_n = tbl[k].rst_n;
      en    = tbl[k].en;
      r_src = tbl[k].src;
      r_tgt = {tbl[k].t1, tbl[k].t0};
      r_alu = {tbl[k].a1, tbl[k].a0};
      step();
      chk($sformatf("v%0d pc_base", k), a_base, tbl[k].e_base);
      chk($sformatf("v%0d lane_valid", k), 32'(a_valid), 32'(tbl[k].e_valid));
      chk($sformatf("v%0d flush", k), 32'(a_fl), 32'(tbl[k].e_fl));
      chk($sformatf("v%0d misalign", k), 32'(a_mis), 32'(tbl[k].e_mis));
      chk($sformatf("v%0d count", k), 32'(a_cnt), 32'(tbl[k].e_cnt));
      chk($sformatf("v%0d pc_lane1", k), a_lane[63:32], tbl[k].e_base + 32'd4);
      check_model(1);
    end

    // Run the 3-bit counter of dut_b into saturation and past it
    rst_n = 1'b1; en = 1'b1; r_src = 4'h1; r_alu = '0;
    for (int k = 0; k < 10; k++) begin
      r_tgt = {32'h0, 32'h1000 + 32'(16 * k)};
      step();
      check_model(0);
      check_model(1);
    end
    chk("sat count_b", 32'(b_cnt), 32'd7);
    chk("sat count_a", 32'(a_cnt), 32'd12);

    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      en    = ($urandom_range(0, 3) != 0);
      r_src = 4'($urandom);
      r_tgt = {$urandom, $urandom};
      r_alu = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) r_tgt[31:0] = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if ($urandom_range(0, 9) == 0) r_alu[63:32] = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if ($urandom_range(0, 2) == 0) r_src = 4'h0;
      step();
      check_model(0);
      check_model(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
